// File: rtl/pc_update_unit.sv
// Program-counter update unit: PC register, branch/jump next-PC selection,
// circular return-address stack and misaligned-target exception capture.
module pc_update_unit #(
  parameter int              WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter logic [31:0]     EXC_VECTOR = 32'h0000_0180,
  parameter int              RAS_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       PCSource,
  input  logic             PCWrite,
  input  logic             PCWriteCond,
  input  logic             Zero,
  input  logic             BranchNe,
  input  logic [WIDTH-1:0] ALU_Result,
  input  logic [WIDTH-1:0] ALUOut,
  input  logic [25:0]      Jump_field,
  input  logic             ras_push,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC_in,
  output logic [WIDTH-1:0] EPC,
  output logic [WIDTH-1:0] BadAddr,
  output logic             exc_misaligned,
  output logic             ras_underflow,
  output logic             ras_empty,
  output logic             ras_full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [WIDTH-1:0] EXC_PC   = WIDTH'(EXC_VECTOR);
  localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(64'h0FFF_FFFF);
  localparam logic [PW:0]      FULL_CNT = (PW + 1)'(RAS_DEPTH);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    ptr, ptr_next, wr_idx;
  logic [PW:0]      count, count_next;
  logic [WIDTH-1:0] jump_target, ras_top;
  logic             upd, pop_req, pop, misaligned;

  assign ras_empty = (count == '0);
  assign ras_full  = (count == FULL_CNT);
  assign ras_top   = ras_mem[ptr];

  // Upper PC bits above bit 27 survive a jump; narrower PCs keep only the low bits.
  assign jump_target = (PC & ~LOW_MASK) | WIDTH'({Jump_field, 2'b00});

  always_comb begin
    PC_in = ALU_Result;
    case (PCSource)
      2'd0: PC_in = ALU_Result;
      2'd1: PC_in = ALUOut;
      2'd2: PC_in = jump_target;
      2'd3: PC_in = ras_empty ? ALUOut : ras_top;
      default: PC_in = ALU_Result;
    endcase
  end

  assign upd        = PCWrite | (PCWriteCond & (Zero ^ BranchNe));
  assign misaligned = |PC_in[1:0];
  assign pop_req    = upd & (PCSource == 2'd3);
  assign pop        = pop_req & ~ras_empty;

  // A push paired with a pop overwrites the current top instead of moving the pointer.
  always_comb begin
    ptr_next   = ptr;
    count_next = count;
    wr_idx     = ptr + 1'b1;
    if (ras_push && pop) begin
      wr_idx = ptr;
    end else if (ras_push) begin
      ptr_next = ptr + 1'b1;
      if (!ras_full) count_next = count + 1'b1;
    end else if (pop) begin
      ptr_next   = ptr - 1'b1;
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      PC             <= RESET_PC;
      EPC            <= '0;
      BadAddr        <= '0;
      ptr            <= '0;
      count          <= '0;
      exc_misaligned <= 1'b0;
      ras_underflow  <= 1'b0;
    end else begin
      ptr            <= ptr_next;
      count          <= count_next;
      exc_misaligned <= upd & misaligned;
      ras_underflow  <= pop_req & ras_empty;
      if (upd) begin
        if (misaligned) begin
          PC      <= EXC_PC;
          EPC     <= PC;
          BadAddr <= PC_in;
        end else begin
          PC <= PC_in;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ras_push) ras_mem[wr_idx] <= PC;
  end

endmodule

// File: tb/tb_pc_update_unit.sv
// Bench for pc_update_unit: directed scenarios followed by random traffic,
// all compared against a queue-based reference model of the PC and RAS.
module tb_pc_update_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  PCSource;
  logic        PCWrite, PCWriteCond, Zero, BranchNe, ras_push;
  logic [31:0] ALU_Result, ALUOut;
  logic [25:0] Jump_field;
  logic [31:0] PC, PC_in, EPC, BadAddr;
  logic        exc_misaligned, ras_underflow, ras_empty, ras_full;

  logic [31:0] m_pc, m_epc, m_bad;
  logic        m_exc, m_uf;
  logic [31:0] m_ras [$];

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  pc_update_unit #(
    .WIDTH(32), .RESET_PC(32'h0), .EXC_VECTOR(32'h0000_0180), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .PCSource(PCSource), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .Zero(Zero), .BranchNe(BranchNe),
    .ALU_Result(ALU_Result), .ALUOut(ALUOut), .Jump_field(Jump_field),
    .ras_push(ras_push), .PC(PC), .PC_in(PC_in), .EPC(EPC), .BadAddr(BadAddr),
    .exc_misaligned(exc_misaligned), .ras_underflow(ras_underflow),
    .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) begin
      passes++;
    end else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_pc_in();
    case (PCSource)
      2'd0: return ALU_Result;
      2'd1: return ALUOut;
      2'd2: return {m_pc[31:28], Jump_field, 2'b00};
      default: return (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : ALUOut;
    endcase
  endfunction

  // One clock of traffic: drive on the falling edge, check the combinational
  // candidate, then advance the model and compare registered state after the edge.
  task automatic applyStimulus(input logic r, input logic [1:0] sel, input logic pw,
                               input logic pwc, input logic z, input logic bne,
                               input logic [31:0] alu_res, input logic [31:0] alu_out,
                               input logic [25:0] jf, input logic push);
    logic [31:0] exp_in;
    logic        upd, pop_try;
    @(negedge clk);
    rst = r; PCSource = sel; PCWrite = pw; PCWriteCond = pwc; Zero = z;
    BranchNe = bne; ALU_Result = alu_res; ALUOut = alu_out; Jump_field = jf;
    ras_push = push;
    #1;
    exp_in = model_pc_in();
    checkOutput("pc_in", PC_in, exp_in);
    if (r) begin
      m_pc = 32'h0; m_epc = 32'h0; m_bad = 32'h0; m_exc = 1'b0; m_uf = 1'b0;
      m_ras.delete();
    end else begin
      upd     = pw | (pwc & (z ^ bne));
      pop_try = upd && (sel == 2'd3);
      m_uf    = pop_try && (m_ras.size() == 0);
      m_exc   = upd && (exp_in[1:0] != 2'b00);
      if (pop_try && m_ras.size() > 0 && push) begin
        m_ras[m_ras.size()-1] = m_pc;
      end else if (pop_try && m_ras.size() > 0) begin
        void'(m_ras.pop_back());
      end else if (push) begin
        m_ras.push_back(m_pc);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
      if (upd) begin
        if (m_exc) begin
          m_epc = m_pc; m_bad = exp_in; m_pc = 32'h0000_0180;
        end else begin
          m_pc = exp_in;
        end
      end
    end
    @(posedge clk);
    #1;
    checkOutput("pc", PC, m_pc);
    checkOutput("epc", EPC, m_epc);
    checkOutput("badaddr", BadAddr, m_bad);
    checkOutput("exc_misaligned", {31'b0, exc_misaligned}, {31'b0, m_exc});
    checkOutput("ras_underflow", {31'b0, ras_underflow}, {31'b0, m_uf});
    checkOutput("ras_empty", {31'b0, ras_empty}, {31'b0, m_ras.size() == 0});
    checkOutput("ras_full", {31'b0, ras_full}, {31'b0, m_ras.size() == DEPTH});
  endtask

  initial begin
    logic [31:0] a, b;
    rst = 1'b1; PCSource = 2'd0; PCWrite = 1'b0; PCWriteCond = 1'b0; Zero = 1'b0;
    BranchNe = 1'b0; ALU_Result = 32'h0; ALUOut = 32'h0; Jump_field = 26'h0;
    ras_push = 1'b0;
    m_pc = 32'h0; m_epc = 32'h0; m_bad = 32'h0; m_exc = 1'b0; m_uf = 1'b0;

    $display("[TB] reset and sequential fetch");
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 26'h0, 0);
    checkOutput("reset_pc", PC, 32'h0);
    for (int i = 1; i <= 3; i++)
      applyStimulus(0, 0, 1, 0, 0, 0, 32'(4 * i), 32'h0, 26'h0, 0);
    checkOutput("fetch_pc", PC, 32'd12);

    $display("[TB] conditional branches");
    applyStimulus(0, 1, 0, 1, 1, 0, 32'h0, 32'h40, 26'h0, 0);
    checkOutput("beq_taken", PC, 32'h40);
    applyStimulus(0, 0, 1, 0, 0, 0, 32'h44, 32'h0, 26'h0, 0);
    applyStimulus(0, 1, 0, 1, 1, 1, 32'h0, 32'h40, 26'h0, 0);
    checkOutput("bne_not_taken", PC, 32'h44);
    applyStimulus(0, 1, 0, 1, 0, 1, 32'h0, 32'h40, 26'h0, 0);
    checkOutput("bne_taken", PC, 32'h40);

    $display("[TB] jump");
    applyStimulus(0, 0, 1, 0, 0, 0, 32'h1000_0010, 32'h0, 26'h0, 0);
    applyStimulus(0, 2, 1, 0, 0, 0, 32'h0, 32'h0, 26'h0000100, 0);
    checkOutput("jump_pc", PC, 32'h1000_0400);

    $display("[TB] misaligned target");
    applyStimulus(0, 0, 1, 0, 0, 0, 32'h22, 32'h0, 26'h0, 0);
    checkOutput("exc_pc", PC, 32'h180);
    checkOutput("exc_epc", EPC, 32'h1000_0400);
    checkOutput("exc_bad", BadAddr, 32'h22);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 26'h0, 0);
    checkOutput("exc_pulse_end", {31'b0, exc_misaligned}, 32'h0);

    $display("[TB] return-address stack overflow and drain");
    applyStimulus(0, 0, 1, 0, 0, 0, 32'h10, 32'h0, 26'h0, 0);
    for (int i = 2; i <= 5; i++)
      applyStimulus(0, 0, 1, 0, 0, 0, 32'(16 * i), 32'h0, 26'h0, 1);
    checkOutput("full_after_4", {31'b0, ras_full}, 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 26'h0, 1);
    for (int i = 5; i >= 2; i--) begin
      applyStimulus(0, 3, 1, 0, 0, 0, 32'h0, 32'h200, 26'h0, 0);
      checkOutput("ras_pop", PC, 32'(16 * i));
    end
    checkOutput("empty_after_4", {31'b0, ras_empty}, 32'h1);
    applyStimulus(0, 3, 1, 0, 0, 0, 32'h0, 32'h200, 26'h0, 0);
    checkOutput("underflow_pc", PC, 32'h200);
    checkOutput("underflow_flag", {31'b0, ras_underflow}, 32'h1);

    $display("[TB] simultaneous push and pop, then reset during push");
    applyStimulus(0, 0, 1, 0, 0, 0, 32'h20, 32'h0, 26'h0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 32'h30, 32'h0, 26'h0, 1);
    applyStimulus(0, 0, 1, 0, 0, 0, 32'h60, 32'h0, 26'h0, 1);
    applyStimulus(0, 3, 1, 0, 0, 0, 32'h0, 32'h200, 26'h0, 1);
    checkOutput("pushpop_pc", PC, 32'h30);
    applyStimulus(0, 3, 1, 0, 0, 0, 32'h0, 32'h200, 26'h0, 0);
    checkOutput("pushpop_next", PC, 32'h60);
    applyStimulus(1, 3, 1, 0, 0, 0, 32'h0, 32'h200, 26'h0, 1);
    checkOutput("rst_pc", PC, 32'h0);
    checkOutput("rst_empty", {31'b0, ras_empty}, 32'h1);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      a = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 9) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
      b = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 9) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
      applyStimulus(($urandom_range(0, 49) == 0), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    a, b, 26'($urandom), 1'($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/pc_update_unit.md
# pc_update_unit

Parametrised program-counter update unit for the multicycle datapath. It extends the plain PC input select with several pieces of sequential logic: the PC register itself, conditional branch write enable (beq/bne), jump-target formation, and a circular return-address stack (RAS) for jal/jr $ra. It also detects misaligned targets, redirecting to an exception vector and capturing EPC/BadAddr. It sits between the control FSM and ALU outputs and the instruction-memory address port.

## Interface
- WIDTH, 32: PC/data width (≥ 8).
- RESET_PC, 0: PC value after reset.
- EXC_VECTOR, 32'h0000_0180: PC loaded on misaligned-target exception (truncated to WIDTH).
- RAS_DEPTH, 4: return-address stack entries (power of two, ≥ 2).

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- PCSource  in  2  0 ALU_Result, 1 ALUOut, 2 jump target, 3 RAS top.
- PCWrite  in  1  unconditional PC write.
- PCWriteCond  in  1  branch write, qualified by Zero/BranchNe.
- Zero  in  1  ALU zero flag.
- BranchNe  in  1  0 = beq sense, 1 = bne sense.
- ALU_Result  in  WIDTH  current ALU output (PC+4).
- ALUOut  in  WIDTH  registered ALU output (branch target).
- Jump_field  in  26  instruction[25:0].
- ras_push  in  1  push return address (jal).
- PC  out  WIDTH  registered program counter.
- PC_in  out  WIDTH  combinational next-PC candidate.
- EPC  out  WIDTH  PC at the faulting update.
- BadAddr  out  WIDTH  offending misaligned target.
- exc_misaligned  out  1  one-cycle exception pulse.
- ras_underflow  out  1  one-cycle pulse: RAS source selected while empty.
- ras_empty, ras_full  out  1  RAS status.

## Operation
- Jump target = {PC[WIDTH-1:28], Jump_field, 2'b00} (for WIDTH < 32, take the low WIDTH bits).
- PC_in is fully defined for all PCSource values. Source 3 yields the RAS top; if the RAS is empty, it yields ALUOut instead.
- Update enable: upd = PCWrite | (PCWriteCond & (Zero ^ BranchNe)).
- On upd with PC_in[1:0] == 0: PC <= PC_in.
- On upd with PC_in[1:0] != 0: PC <= EXC_VECTOR, EPC <= PC, BadAddr <= PC_in, exc_misaligned = 1 for the next cycle. A RAS pop on this same edge still occurs.
- No upd: PC, EPC and BadAddr hold.
- RAS is a circular buffer with top pointer and count (0..RAS_DEPTH):
  - Pop occurs when upd and PCSource == 3 and count > 0: pointer decrements, count decrements.
  - ras_push (independent of upd) writes the current PC register value at pointer+1, then the pointer increments.
  - Push when full: count stays RAS_DEPTH and the oldest entry is overwritten (wrap-around).
  - Push and pop on the same edge: the top entry is replaced with PC; pointer and count are unchanged.
  - Pop with count == 0: no pointer change; ras_underflow pulses next cycle.
- Reset values: PC = RESET_PC, EPC = 0, BadAddr = 0, count = 0, pointer = 0, exc_misaligned = 0, ras_underflow = 0, ras_empty = 1, ras_full = 0.

## Timing
- PC_in is combinational from the inputs and current state, with zero latency.
- PC, EPC, BadAddr and the RAS update on the clk edge where they are enabled; new values are visible one cycle later.
- exc_misaligned and ras_underflow are registered and high for exactly one cycle after the causing edge.
- ras_empty and ras_full are derived from the registered count.
- rst has priority over all other inputs. Asserting it mid-operation (including during a push/pop) discards the operation and applies the reset values on that edge.
- No combinational path exists from PCWrite/PCWriteCond to PC_in.

## Test plan
- Reset, then PCWrite=1, PCSource=0, ALU_Result=4 for 3 cycles, with ALU_Result stepping 4, 8, 12 -> PC = 0, 4, 8, 12 on successive cycles.
- PCWriteCond=1, PCSource=1, ALUOut=0x40: with Zero=1, BranchNe=0 -> PC=0x40. With Zero=1, BranchNe=1 -> PC holds. With Zero=0, BranchNe=1 -> PC=0x40.
- PC=0x1000_0010, PCSource=2, Jump_field=0x0000100, PCWrite=1 -> PC=0x1000_0400.
- PCWrite=1, PCSource=0, ALU_Result=0x22 -> PC=0x180, EPC=old PC, BadAddr=0x22, exc_misaligned high for exactly 1 cycle.
- RAS_DEPTH=4: push 5 times with PC=0x10, 0x20, 0x30, 0x40, 0x50, then perform 5 pops via PCSource=3 with PCWrite=1:
  - pops yield 0x50, 0x40, 0x30, 0x20;
  - the fifth pop gives PC=ALUOut and ras_underflow=1;
  - ras_full is 1 after the 4th push and ras_empty is 1 after the 4th pop.
- Simultaneous push and pop with RAS holding {0x20, 0x30}, PC=0x60: count stays 2 and the next pop returns 0x60. Then assert rst during a push -> count=0, PC=RESET_PC.
